// File: rtl/reset_seq_ctrlr.sv
// -----------------------------------------------------------------------------
// reset_seq_ctrlr
//   Generates NUM_CH active-high reset outputs from a single board reset.
//   All outputs assert asynchronously with in_rst_n. They are released
//   synchronously, one channel at a time in index order. The sequence starts
//   only after a hold period in which the synchronised reset release and the
//   synchronised PLL lock are both present and no soft reset is requested.
//   Loss of lock or a soft reset after the first release aborts the sequence
//   and re-asserts every channel.
//
// Ports
//   in_clk      : system clock; all logic runs in this domain
//   in_rst_n    : async active-low board reset (release is synchronised)
//   in_lock     : async PLL/DCM lock; synchronised internally; 0 forces reset
//   in_soft_rst : sync active-high soft reset request, level-sensitive
//   out_rst     : per-channel reset, active-high, ch0 released first
//   out_busy    : 1 while any channel is still asserted (registered)
//   out_done    : 1 once all channels are released (registered)
// -----------------------------------------------------------------------------
module reset_seq_ctrlr #(
    parameter int NUM_CH      = 3,
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGE_GAP   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              in_clk,
    input  logic              in_rst_n,
    input  logic              in_lock,
    input  logic              in_soft_rst,
    output logic [NUM_CH-1:0] out_rst,
    output logic              out_busy,
    output logic              out_done
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    // Index of the channel released just before the final one.
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'((NUM_CH > 1) ? (NUM_CH - 2) : 0);
    localparam logic [NUM_CH-1:0] ALL_SET   = '1;

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_RELEASE,
        ST_DONE
    } state_e;

    // -------------------------------------------------------------------------
    // Synchronisers: reset release shifts in 1, lock shifts in in_lock.
    // Both clear to 0 so a board reset also drops the qualified lock.
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] rst_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   rst_ok;
    logic                   lock_s;

    // NOTE: sequential state uses non-blocking assignments only; the async
    // clear gives every flop a defined value without needing a clock.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            rst_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            rst_sync_q  <= {rst_sync_q[SYNC_STAGES-2:0], 1'b1};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], in_lock};
        end
    end

    assign rst_ok = rst_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------------
    // Sequencer
    // -------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [NUM_CH-1:0]  rst_q,   rst_d;
    logic               busy_q;
    logic               done_q;
    logic               abort;

    assign abort = !lock_s || in_soft_rst;

    // NOTE: every next-state signal takes a default first, so no path through
    // this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rst_d   = rst_q;

        unique case (state_q)
            ST_ASSERT: begin
                rst_d = ALL_SET;
                if (rst_ok && lock_s && !in_soft_rst) begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        rst_d   = ALL_SET << 1;   // release ch0
                        state_d = (NUM_CH == 1) ? ST_DONE : ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    // Any disqualifying input restarts the hold from zero.
                    cnt_d = '0;
                end
            end

            ST_RELEASE: begin
                // Abort wins over a release falling on the same edge.
                if (abort) begin
                    state_d = ST_ASSERT;
                    rst_d   = ALL_SET;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    // Released channels are always the low bits, so shifting
                    // in one more zero releases channel idx+1.
                    rst_d = rst_q << 1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_DONE: begin
                if (abort) begin
                    state_d = ST_ASSERT;
                    rst_d   = ALL_SET;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = ST_ASSERT;
                rst_d   = ALL_SET;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_q   <= ALL_SET;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_q   <= rst_d;
            // Status flags are registered from the next-state values so they
            // change on the same edge as out_rst.
            busy_q  <= |rst_d;
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign out_rst  = rst_q;
    assign out_busy = busy_q;
    assign out_done = done_q;

endmodule

// File: tb/tb_reset_seq_ctrlr.sv
// -----------------------------------------------------------------------------
// tb_reset_seq_ctrlr
//   Drives a 3-channel and a 1-channel reset_seq_ctrlr from shared inputs.
//   A behavioural model tracks how many consecutive qualified edges have
//   elapsed ("run") and derives the number of released channels from it with
//   plain arithmetic. A compare process checks both DUTs against the model
//   on every falling edge; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_reset_seq_ctrlr;

    localparam int NCH     = 3;
    localparam int HOLD    = 8;
    localparam int GAP     = 4;
    localparam int SYNC    = 2;
    localparam int RUN_CAP = HOLD + GAP * NCH;

    logic           in_clk = 1'b0;
    logic           in_rst_n;
    logic           in_lock;
    logic           in_soft_rst;
    logic [NCH-1:0] out_rst;
    logic           out_busy;
    logic           out_done;
    logic [0:0]     out_rst1;
    logic           out_busy1;
    logic           out_done1;

    int  n_pass  = 0;
    int  n_total = 0;
    bit  chk_en  = 1'b0;

    always #10 in_clk = ~in_clk;

    reset_seq_ctrlr #(
        .NUM_CH(NCH), .CNT_W(16), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .SYNC_STAGES(SYNC)
    ) u_dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_lock(in_lock), .in_soft_rst(in_soft_rst),
        .out_rst(out_rst), .out_busy(out_busy), .out_done(out_done)
    );

    reset_seq_ctrlr #(
        .NUM_CH(1), .CNT_W(16), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .SYNC_STAGES(SYNC)
    ) u_dut1 (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_lock(in_lock), .in_soft_rst(in_soft_rst),
        .out_rst(out_rst1), .out_busy(out_busy1), .out_done(out_done1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Channels released after 'run' consecutive qualified edges.
    function automatic int rel_count(input int run, input int nch);
        int n;
        if (run < HOLD) return 0;
        n = 1 + (run - HOLD) / GAP;
        return (n > nch) ? nch : n;
    endfunction

    // ---------------------------------------------------------------- model
    int             run     = 0;
    int             rst_cnt = 0;          // edges seen with in_rst_n high
    logic [SYNC-1:0] lock_hist = '0;      // lock samples, newest in bit 0

    always @(posedge in_clk or negedge in_rst_n) begin
        int  rel;
        bit  rst_ok;
        bit  lk;
        if (!in_rst_n) begin
            run       = 0;
            rst_cnt   = 0;
            lock_hist = '0;
        end else begin
            rel    = rel_count(run, NCH);
            rst_ok = (rst_cnt >= SYNC);
            lk     = lock_hist[SYNC-1];
            if (rel == 0)
                run = (rst_ok && lk && !in_soft_rst) ? run + 1 : 0;
            else
                run = (lk && !in_soft_rst) ? ((run + 1 > RUN_CAP) ? RUN_CAP : run + 1) : 0;
            if (rst_cnt < SYNC) rst_cnt++;
            lock_hist = {lock_hist[SYNC-2:0], in_lock};
        end
    end

    // -------------------------------------------------------------- compare
    always @(negedge in_clk) begin
        int             rel;
        int             rel1;
        logic [NCH-1:0] exp_rst;
        logic [NCH-1:0] inv;
        if (chk_en) begin
            rel     = rel_count(run, NCH);
            rel1    = rel_count(run, 1);
            exp_rst = {NCH{1'b1}} << rel;
            check("out_rst",  32'(out_rst),  32'(exp_rst));
            check("out_busy", 32'(out_busy), 32'(rel < NCH));
            check("out_done", 32'(out_done), 32'(rel == NCH));
            check("ch1_rst",  32'(out_rst1), 32'(rel1 == 0));
            check("ch1_busy", 32'(out_busy1), 32'(rel1 == 0));
            check("ch1_done", 32'(out_done1), 32'(rel1 == 1));
            // Released channels must be a contiguous run of low bits.
            inv = ~out_rst;
            check("order_shape", 32'((inv & (inv + 1'b1)) == '0), 32'd1);
            check("busy_is_or",  32'(out_busy), 32'(|out_rst));
        end
    end

    // ------------------------------------------------------------ scenarios
    task automatic hold_reset();
        in_rst_n = 1'b0;
        repeat (2) @(posedge in_clk);
        #5;
    endtask

    // Release in_rst_n before E0 and check the documented edge timing.
    task automatic powerup(input string tag);
        in_rst_n = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(posedge in_clk);
            @(negedge in_clk);
            case (k)
                8:  begin
                        check({tag, "_e8_rst"},   32'(out_rst), 32'b111);
                        check({tag, "_e8_done1"}, 32'(out_done1), 32'd0);
                    end
                9:  begin
                        check({tag, "_e9_rst"},   32'(out_rst), 32'b110);
                        check({tag, "_e9_done1"}, 32'(out_done1), 32'd1);
                    end
                12: check({tag, "_e12_rst"}, 32'(out_rst), 32'b110);
                13: check({tag, "_e13_rst"}, 32'(out_rst), 32'b100);
                16: begin
                        check({tag, "_e16_rst"},  32'(out_rst), 32'b100);
                        check({tag, "_e16_done"}, 32'(out_done), 32'd0);
                    end
                17: begin
                        check({tag, "_e17_rst"},  32'(out_rst), 32'b000);
                        check({tag, "_e17_done"}, 32'(out_done), 32'd1);
                        check({tag, "_e17_busy"}, 32'(out_busy), 32'd0);
                    end
                default: ;
            endcase
        end
        @(posedge in_clk);
        #5;
    endtask

    initial begin
        in_rst_n    = 1'b1;
        in_lock     = 1'b1;
        in_soft_rst = 1'b0;
        #2 in_rst_n = 1'b0;
        chk_en      = 1'b1;
        repeat (3) @(posedge in_clk);
        #5;

        // Power-up sequence.
        powerup("pu");
        repeat (3) @(posedge in_clk);
        #5;

        // Async reset while DONE: outputs must change with no clock edge.
        check("pre_async_done", 32'(out_done), 32'd1);
        in_rst_n = 1'b0;
        #1;
        check("async_rst", 32'(out_rst), 32'b111);
        check("async_done", 32'(out_done), 32'd0);
        check("async_busy", 32'(out_busy), 32'd1);
        check("async_rst1", 32'(out_rst1), 32'd1);
        @(posedge in_clk);
        #5;
        powerup("replay");

        // Lock glitch during the hold at cnt=5.
        hold_reset();
        in_rst_n = 1'b1;
        repeat (7) @(posedge in_clk);
        #5 in_lock = 1'b0;
        repeat (3) @(posedge in_clk);
        #5 in_lock = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge in_clk);
            @(negedge in_clk);
            if (k == 9)  check("lock_k9_rst",  32'(out_rst), 32'b111);
            if (k == 10) check("lock_k10_rst", 32'(out_rst), 32'b110);
        end
        @(posedge in_clk);
        #5;

        // Soft reset during RELEASE with ch0 released.
        hold_reset();
        in_rst_n = 1'b1;
        repeat (10) @(posedge in_clk);
        #5 in_soft_rst = 1'b1;
        @(negedge in_clk);
        check("soft_pre_rst", 32'(out_rst), 32'b110);
        @(posedge in_clk);
        #5 in_soft_rst = 1'b0;
        @(negedge in_clk);
        check("soft_abort_rst", 32'(out_rst), 32'b111);
        for (int k = 11; k <= 18; k++) begin
            @(posedge in_clk);
            @(negedge in_clk);
            if (k == 17) check("soft_e17_rst", 32'(out_rst), 32'b111);
            if (k == 18) check("soft_e18_rst", 32'(out_rst), 32'b110);
        end
        @(posedge in_clk);
        #5;

        // Abort on the same edge as the ch1 release.
        hold_reset();
        in_rst_n = 1'b1;
        repeat (13) @(posedge in_clk);
        #5 in_soft_rst = 1'b1;
        @(negedge in_clk);
        check("coll_pre_rst", 32'(out_rst), 32'b110);
        @(posedge in_clk);
        #5 in_soft_rst = 1'b0;
        @(negedge in_clk);
        check("coll_rst",  32'(out_rst), 32'b111);
        check("coll_done", 32'(out_done), 32'd0);
        @(posedge in_clk);
        #5;

        // Randomised lock drops, soft resets and board resets.
        for (int c = 0; c < 3000; c++) begin
            if (!in_rst_n)
                in_rst_n = 1'b1;
            else if ($urandom_range(0, 199) == 0)
                in_rst_n = 1'b0;
            if (in_lock) begin
                if ($urandom_range(0, 99) < 2) in_lock = 1'b0;
            end else if ($urandom_range(0, 99) < 30) begin
                in_lock = 1'b1;
            end
            in_soft_rst = ($urandom_range(0, 99) < 2);
            @(posedge in_clk);
            #5;
        end

        // Settle cleanly so the last run finishes its sequence.
        in_rst_n    = 1'b1;
        in_lock     = 1'b1;
        in_soft_rst = 1'b0;
        repeat (30) @(posedge in_clk);
        @(negedge in_clk);
        check("final_done", 32'(out_done), 32'd1);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
